// File: rtl/udp_rx_stream_checker.sv
// udp_rx_stream_checker
//   AXIS sink/checker for the 400G UDP streaming RX path. Every beat is
//   accepted when tvalid & tready. Each beat is checked for:
//     - the lane-index payload pattern (byte lane i == i[7:0] where kept),
//     - tkeep shape (full on non-last beats; contiguous from lane 0 and
//       nonzero on the last beat),
//     - packet byte length (saturating count versus expected_packet_length),
//     - tuser.
//   Completion results appear one cycle after the tlast handshake.
//
// Ports
//   s_axis_aclk / s_axis_aresetn : clock, asynchronous active-low reset
//   s_axis_t*                    : AXIS sink (tdata/tkeep/tvalid/tready/tlast/tuser)
//   expected_packet_length       : expected bytes per packet, 0 = no length check
//   clear_counters               : synchronous clear of counters and sticky flags
//   pkt_count / err_count        : wrapping packet and errored-packet counters
//   last_pkt_bytes               : byte count of the most recent packet
//   pkt_done / pkt_err           : one-cycle completion / error pulses
//   err_flags                    : sticky [0] data [1] keep [2] length [3] tuser
//
// Configuration
//   RX_CHECK_BACKPRESSURE_EN : when defined, a 16-bit LFSR throttles
//                              s_axis_tready (~75% duty).
module udp_rx_stream_checker #(
  parameter int G_AXIS_DATA_WIDTH = 1024,
  parameter int G_LEN_WIDTH       = 16
) (
  input  logic                           s_axis_aclk,
  input  logic                           s_axis_aresetn,
  input  logic [G_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic [G_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                           s_axis_tlast,
  input  logic                           s_axis_tuser,
  input  logic [G_LEN_WIDTH-1:0]         expected_packet_length,
  input  logic                           clear_counters,
  output logic [31:0]                    pkt_count,
  output logic [31:0]                    err_count,
  output logic [G_LEN_WIDTH-1:0]         last_pkt_bytes,
  output logic                           pkt_done,
  output logic                           pkt_err,
  output logic [3:0]                     err_flags
);

  localparam int KEEP_W = G_AXIS_DATA_WIDTH / 8;

  typedef enum logic {
    ST_IDLE,
    ST_BODY
  } state_t;

  state_t                  state_q, state_d;
  logic                    ready_q;
  logic                    beat_ok;
  logic [G_LEN_WIDTH:0]    byte_add;
  logic [G_LEN_WIDTH:0]    sum;
  logic [G_LEN_WIDTH-1:0]  cnt_q;
  logic [G_LEN_WIDTH-1:0]  cnt_d;
  logic [3:0]              pkt_err_q;
  logic [3:0]              beat_err;
  logic [3:0]              err_tot;
  logic                    data_bad;
  logic                    keep_bad;
  logic                    len_bad;
  logic [KEEP_W-1:0]       keep_inc;

`ifdef RX_CHECK_BACKPRESSURE_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR, taps 16,14,13,11.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  // ready_q keeps tready low throughout reset regardless of the LFSR seed.
  assign s_axis_tready = ready_q & (|lfsr_q[1:0]);
`else
  assign s_axis_tready = ready_q;
`endif

  assign beat_ok = s_axis_tvalid & s_axis_tready;

  // Per-beat checks and running byte count.
  always_comb begin
    byte_add = '0;
    data_bad = 1'b0;
    for (int unsigned i = 0; i < KEEP_W; i++) begin
      byte_add = byte_add + (G_LEN_WIDTH+1)'(s_axis_tkeep[i]);
      if (s_axis_tkeep[i] && (s_axis_tdata[8*i +: 8] != 8'(i))) begin
        data_bad = 1'b1;
      end
    end

    // First beat of a packet starts from zero, whatever the stale count holds.
    sum   = ((state_q == ST_BODY) ? {1'b0, cnt_q} : '0) + byte_add;
    cnt_d = sum[G_LEN_WIDTH] ? '1 : sum[G_LEN_WIDTH-1:0];

    keep_inc = s_axis_tkeep + KEEP_W'(1);
    if (s_axis_tlast) begin
      keep_bad = (s_axis_tkeep == '0) || ((s_axis_tkeep & keep_inc) != '0);
    end else begin
      keep_bad = (s_axis_tkeep != '1);
    end

    len_bad = sum[G_LEN_WIDTH] ||
              (s_axis_tlast && (expected_packet_length != '0) &&
               (cnt_d != expected_packet_length));

    beat_err = {s_axis_tuser, len_bad, keep_bad, data_bad};
    err_tot  = ((state_q == ST_BODY) ? pkt_err_q : '0) | beat_err;
  end

  always_comb begin
    state_d = state_q;
    if (beat_ok) begin
      state_d = s_axis_tlast ? ST_IDLE : ST_BODY;
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      ready_q        <= 1'b0;
      cnt_q          <= '0;
      pkt_err_q      <= '0;
      pkt_count      <= '0;
      err_count      <= '0;
      last_pkt_bytes <= '0;
      pkt_done       <= 1'b0;
      pkt_err        <= 1'b0;
      err_flags      <= '0;
    end else begin
      ready_q  <= 1'b1;
      pkt_done <= beat_ok & s_axis_tlast;
      pkt_err  <= beat_ok & s_axis_tlast & (|err_tot);
      if (beat_ok) begin
        cnt_q     <= cnt_d;
        pkt_err_q <= err_tot;
      end
      // Clear wins over a coinciding completion; the pulses above still fire.
      if (clear_counters) begin
        pkt_count      <= '0;
        err_count      <= '0;
        last_pkt_bytes <= '0;
        err_flags      <= '0;
      end else if (beat_ok && s_axis_tlast) begin
        pkt_count      <= pkt_count + 32'd1;
        last_pkt_bytes <= cnt_d;
        if (|err_tot) begin
          err_count <= err_count + 32'd1;
          err_flags <= err_flags | err_tot;
        end
      end
    end
  end

endmodule
